// File: rtl/aritmetica_pkg.sv
// rtl/aritmetica_pkg.sv - shared fixed-point format constants and data word type
package aritmetica_pkg;

  localparam int W = 24;
  localparam int F = 10;

  typedef logic signed [W-1:0] data_t;

  localparam data_t SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam data_t SAT_MIN = {1'b1, {(W-1){1'b0}}};

endpackage

// File: rtl/aritmetica_saturador.sv
// rtl/aritmetica_saturador.sv - clamps a wide signed value into an OUT_W-bit signed word
module saturador
  import aritmetica_pkg::*;
#(
  parameter int IN_W  = 2*W + 1,
  parameter int OUT_W = W
) (
  input  logic signed [IN_W-1:0]  wide,
  output logic signed [OUT_W-1:0] sat
);

  // Limits expressed at the input width so the comparison stays exact.
  localparam logic signed [IN_W-1:0] LIM_MAX = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] LIM_MIN = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    sat = wide[OUT_W-1:0];
    if (wide > LIM_MAX) begin
      sat = LIM_MAX[OUT_W-1:0];
    end else if (wide < LIM_MIN) begin
      sat = LIM_MIN[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/aritmetica.sv
// rtl/aritmetica.sv - two-stage saturating fixed-point multiply-add: C + ((M*E) >>> F)
module aritmetica #(
  parameter int W = aritmetica_pkg::W,
  parameter int F = aritmetica_pkg::F
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic signed [W-1:0] Constantes_G,
  input  logic signed [W-1:0] Multip_G,
  input  logic signed [W-1:0] Entrada_G,
  output logic signed [W-1:0] Valores,
  output logic                out_valid
);

  logic signed [2*W-1:0] prod;
  logic signed [2*W-1:0] prod_sh;
  logic signed [2*W-1:0] s1_prod;
  logic signed [W-1:0]   s1_const;
  logic                  s1_valid;
  logic signed [2*W:0]   sum;
  logic signed [W-1:0]   sat_val;

  // Full-precision product; the arithmetic shift floors toward -inf.
  assign prod    = (2*W)'(Multip_G) * (2*W)'(Entrada_G);
  assign prod_sh = prod >>> F;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_prod  <= '0;
      s1_const <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_prod  <= prod_sh;
      s1_const <= Constantes_G;
      s1_valid <= in_valid;
    end
  end

  // One extra bit over the product width guarantees the add cannot wrap.
  assign sum = (2*W+1)'(s1_prod) + (2*W+1)'(s1_const);

  saturador #(
    .IN_W (2*W + 1),
    .OUT_W(W)
  ) u_saturador (
    .wide(sum),
    .sat (sat_val)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      Valores   <= '0;
      out_valid <= 1'b0;
    end else begin
      Valores   <= sat_val;
      out_valid <= s1_valid;
    end
  end

endmodule

// File: tb/tb_aritmetica.sv
// tb/tb_aritmetica.sv - self-checking bench for aritmetica against an integer reference model
module tb_aritmetica;
  import aritmetica_pkg::*;

  logic  clk = 1'b0;
  logic  reset;
  logic  in_valid;
  data_t c_in, m_in, e_in;
  data_t valores;
  logic  out_valid;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit           rst;
    bit           v;
    logic [W-1:0] val;
    bit           has_spec;
    logic [W-1:0] spec;
  } rec_t;

  rec_t hist[$];

  always #5 clk = ~clk;

  aritmetica #(.W(W), .F(F)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .Constantes_G(c_in),
    .Multip_G    (m_in),
    .Entrada_G   (e_in),
    .Valores     (valores),
    .out_valid   (out_valid)
  );

  function automatic logic [W-1:0] ref_model(data_t c, data_t m, data_t e);
    longint p, s, hi, lo;
    hi = (longint'(1) <<< (W-1)) - 1;
    lo = -(longint'(1) <<< (W-1));
    p  = longint'(m) * longint'(e);
    s  = longint'(c) + (p >>> F);
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return s[W-1:0];
  endfunction

  task automatic check_val(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_bit(string tag, logic got, logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Result after an edge belongs to the inputs sampled one edge earlier,
  // unless either of the last two edges saw reset.
  task automatic step(bit rst, bit v, data_t ci, data_t mi, data_t ei,
                      bit hs, logic [W-1:0] sp);
    rec_t r, prev;
    int   k;
    reset    = rst;
    in_valid = v;
    c_in     = ci;
    m_in     = mi;
    e_in     = ei;
    r.rst = rst; r.v = v; r.val = ref_model(ci, mi, ei); r.has_spec = hs; r.spec = sp;
    @(posedge clk);
    hist.push_back(r);
    if (hist.size() > 2) void'(hist.pop_front());
    @(negedge clk);
    k = hist.size() - 1;
    if (hist[k].rst || (k > 0 && hist[k-1].rst)) begin
      check_bit("reset_out_valid", out_valid, 1'b0);
      check_val("reset_valores", valores, '0);
    end else if (k > 0) begin
      prev = hist[k-1];
      check_bit("out_valid", out_valid, prev.v);
      if (prev.v) begin
        if (prev.has_spec) check_val("directed", valores, prev.spec);
        else               check_val("model", valores, prev.val);
      end
    end
  endtask

  function automatic data_t rand_word();
    case ($urandom_range(0, 7))
      0:       return SAT_MAX;
      1:       return SAT_MIN;
      2:       return data_t'($urandom_range(0, 4096)) - data_t'(2048);
      default: return data_t'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; c_in = '0; m_in = '0; e_in = '0;
    @(negedge clk);

    step(1, 0, '0, '0, '0, 0, '0);
    step(1, 1, 24'h123456, 24'h654321, 24'h0ABCDE, 0, '0);

    step(0, 1, 24'h000400, 24'h000800, 24'h000C00, 1, 24'h001C00);
    step(0, 1, 24'h000000, 24'hFFFC00, 24'h000800, 1, 24'hFFF800);
    step(0, 1, 24'h000000, 24'hFFFFFF, 24'h000001, 1, 24'hFFFFFF);
    step(0, 1, 24'h000000, 24'h000001, 24'h000001, 1, 24'h000000);
    step(0, 1, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 1, 24'h7FFFFF);
    step(0, 1, 24'h800000, 24'hFFFC00, 24'h000400, 1, 24'h800000);
    step(0, 0, rand_word(), rand_word(), rand_word(), 0, '0);
    step(0, 0, rand_word(), rand_word(), rand_word(), 0, '0);

    step(0, 1, rand_word(), rand_word(), rand_word(), 0, '0);
    step(0, 0, rand_word(), rand_word(), rand_word(), 0, '0);
    step(0, 1, rand_word(), rand_word(), rand_word(), 0, '0);
    step(0, 0, '0, '0, '0, 0, '0);
    step(0, 0, '0, '0, '0, 0, '0);

    step(0, 1, 24'h000400, 24'h000400, 24'h000400, 0, '0);
    step(0, 1, 24'h7FFFFF, 24'h000400, 24'h000400, 0, '0);
    step(1, 1, 24'h000400, 24'h000400, 24'h000400, 0, '0);
    step(0, 0, '0, '0, '0, 0, '0);
    step(0, 0, '0, '0, '0, 0, '0);
    step(0, 1, 24'h000001, 24'h000400, 24'h000400, 1, 24'h000401);
    step(0, 0, '0, '0, '0, 0, '0);
    step(0, 0, '0, '0, '0, 0, '0);

    for (int i = 0; i < 5000; i++) begin
      step(0, 1, rand_word(), rand_word(), rand_word(), 0, '0);
    end
    step(0, 0, '0, '0, '0, 0, '0);
    step(0, 0, '0, '0, '0, 0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
